// File: rtl/sysid_pkg.sv
// Shared constants for the sysid reader: FSM state encoding, slave word
// addresses and the default expected ID/timestamp values.
package sysid_pkg;

    // FSM state encoding (plain constants so older tools can share it)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ_ID = 3'd1;
    localparam logic [2:0] ST_LAT_ID = 3'd2;
    localparam logic [2:0] ST_REQ_TS = 3'd3;
    localparam logic [2:0] ST_LAT_TS = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

    // Word addresses inside the sysid slave
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Default expected contents of the sysid slave
    localparam logic [31:0] DEF_EXPECTED_ID = 32'h421EEA87;
    localparam logic [31:0] DEF_EXPECTED_TS = 32'h4C2131D2;

    // True in the states that drive a read request onto the bus
    function automatic logic is_req_state(input logic [2:0] st);
        return (st == ST_REQ_ID) || (st == ST_REQ_TS);
    endfunction

endpackage

// File: rtl/sysid_lat_pipe.sv
// Read-latency tracker: delays the read-accept pulse by a fixed number of
// cycles so the reader knows exactly when readdata is valid.
module sysid_lat_pipe #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic accept,
    output logic capture
);

    if (LATENCY == 0) begin : g_lat0
        // Zero latency: data is valid in the accept cycle itself
        assign capture = accept;
    end else if (LATENCY == 1) begin : g_lat1
        logic vld;

        // Single-stage valid tracker
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) vld <= 1'b0;
            else          vld <= accept;
        end

        assign capture = vld;
    end else begin : g_latn
        logic [LATENCY-1:0] vld;

        // Valid shift register; reset drops any read still in flight
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) vld <= '0;
            else          vld <= {vld[LATENCY-2:0], accept};
        end

        assign capture = vld[LATENCY-1];
    end

endmodule

// File: rtl/sysid_reader.sv
// Reads the system ID and build timestamp words from an Avalon-MM sysid
// slave, compares them with the expected values and reports the result.
module sysid_reader
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
    parameter int          READ_LATENCY   = 1,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        master_address,
    output logic        master_read,
    input  logic        master_waitrequest,
    input  logic [31:0] master_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // Last stall cycle before the read is abandoned
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] stall_cnt;
    logic        in_req;
    logic        accept;
    logic        stall_hit;
    logic        capture;
    logic        capture_id;
    logic        capture_ts;

    assign in_req     = is_req_state(state);
    assign accept     = in_req && !master_waitrequest;
    assign stall_hit  = in_req && master_waitrequest && (stall_cnt == STALL_LIMIT);
    assign capture_id = capture && ((state == ST_REQ_ID) || (state == ST_LAT_ID));
    assign capture_ts = capture && ((state == ST_REQ_TS) || (state == ST_LAT_TS));

    // Bus and status outputs decode straight from the state register
    assign master_read    = in_req;
    assign master_address = (state == ST_REQ_TS) ? ADDR_TS : ADDR_ID;
    assign busy           = (state != ST_IDLE);
    assign done           = (state == ST_FIN);

    sysid_lat_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_lat_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .accept  (accept),
        .capture (capture)
    );

    // Next-state logic; with zero latency capture arrives with the accept
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_REQ_ID;
            ST_REQ_ID: begin
                if (accept)         state_nxt = capture ? ST_REQ_TS : ST_LAT_ID;
                else if (stall_hit) state_nxt = ST_FIN;
            end
            ST_LAT_ID: if (capture) state_nxt = ST_REQ_TS;
            ST_REQ_TS: begin
                if (accept)         state_nxt = capture ? ST_FIN : ST_LAT_TS;
                else if (stall_hit) state_nxt = ST_FIN;
            end
            ST_LAT_TS: if (capture) state_nxt = ST_FIN;
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Stall counter: zero outside a request and on accept, so each read starts fresh
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           stall_cnt <= '0;
        else if (!in_req || !master_waitrequest) stall_cnt <= '0;
        else                                    stall_cnt <= stall_cnt + 16'd1;
    end

    // Captured words and verdicts; cleared on start, held until the next start
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: these are plain registers, not a memory, so they are reset like any other flop.
        if (!reset_n) begin
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                id_ok    <= 1'b0;
                ts_ok    <= 1'b0;
                timeout  <= 1'b0;
                id_value <= '0;
                ts_value <= '0;
            end
            if (capture_id) begin
                id_value <= master_readdata;
                id_ok    <= (master_readdata == EXPECTED_ID);
            end
            if (capture_ts) begin
                ts_value <= master_readdata;
                ts_ok    <= (master_readdata == EXPECTED_TS);
            end
            if (stall_hit) begin
                timeout  <= 1'b1;
                ts_ok    <= 1'b0;
                ts_value <= '0;
                if (state == ST_REQ_ID) begin
                    id_ok    <= 1'b0;
                    id_value <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sysid_reader.sv
// Directed bench for sysid_reader: three instances (latency 0, 1 and 3)
// each served by a small sysid slave model driven from one initial block.
module tb_sysid_reader;

    localparam logic [31:0] GOOD_ID = 32'h421EEA87;
    localparam logic [31:0] GOOD_TS = 32'h4C2131D2;
    localparam logic [31:0] BAD_TS  = 32'h4C2131D3;
    localparam logic [31:0] JUNK    = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] id_data;
    logic [31:0] ts_data;

    // Index 0: latency 0, index 1: latency 1 (timeout 4), index 2: latency 3
    logic        start_v [3];
    logic        addr    [3];
    logic        mr      [3];
    logic        wr      [3];
    logic [31:0] rdata   [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        idok    [3];
    logic        tsok    [3];
    logic        tmo     [3];
    logic [31:0] idv     [3];
    logic [31:0] tsv     [3];

    logic [3:0] sv [3] = '{4'd0, 4'd0, 4'd0};
    logic [3:0] sa [3] = '{4'd0, 4'd0, 4'd0};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sysid_reader #(.READ_LATENCY(0)) dut_l0 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]),
        .master_address(addr[0]), .master_read(mr[0]),
        .master_waitrequest(wr[0]), .master_readdata(rdata[0]),
        .busy(busy_v[0]), .done(done_v[0]), .id_ok(idok[0]), .ts_ok(tsok[0]),
        .timeout(tmo[0]), .id_value(idv[0]), .ts_value(tsv[0])
    );

    sysid_reader #(.READ_LATENCY(1), .TIMEOUT_CYCLES(4)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]),
        .master_address(addr[1]), .master_read(mr[1]),
        .master_waitrequest(wr[1]), .master_readdata(rdata[1]),
        .busy(busy_v[1]), .done(done_v[1]), .id_ok(idok[1]), .ts_ok(tsok[1]),
        .timeout(tmo[1]), .id_value(idv[1]), .ts_value(tsv[1])
    );

    sysid_reader #(.READ_LATENCY(3)) dut_l3 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]),
        .master_address(addr[2]), .master_read(mr[2]),
        .master_waitrequest(wr[2]), .master_readdata(rdata[2]),
        .busy(busy_v[2]), .done(done_v[2]), .id_ok(idok[2]), .ts_ok(tsok[2]),
        .timeout(tmo[2]), .id_value(idv[2]), .ts_value(tsv[2])
    );

    // Slave model: remember accepted reads, return data only in the exact latency slot
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            sv[k] <= {sv[k][2:0], mr[k] & ~wr[k]};
            sa[k] <= {sa[k][2:0], addr[k]};
        end
    end

    // Slave read data; junk outside the valid slot exposes mistimed captures
    always_comb begin
        rdata[0] = (mr[0] && !wr[0]) ? (addr[0] ? ts_data : id_data) : JUNK;
        rdata[1] = sv[1][0] ? (sa[1][0] ? ts_data : id_data) : JUNK;
        rdata[2] = sv[2][2] ? (sa[2][2] ? ts_data : id_data) : JUNK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full check sequence on instance k; stall_id/stall_ts are waitrequest
    // cycles applied to each read, busy_starts pulses start in cycles 2 and 3.
    task automatic run_seq(input int k, input int stall_id, input int stall_ts,
                           input bit busy_starts, input int exp_done,
                           input int exp_acc, input int exp_stall, input string tag);
        int   sid_l     = stall_id;
        int   sts_l     = stall_ts;
        int   done_cyc  = -1;
        int   first_rd  = -1;
        int   n_acc     = 0;
        int   n_stall   = 0;
        int   proto_err = 0;
        logic prev_mr   = 1'b0;
        logic prev_wr   = 1'b0;
        logic prev_addr = 1'b0;
        logic busy_c1   = 1'b0;
        @(negedge clk);
        start_v[k] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start_v[k] = busy_starts && (c == 2 || c == 3);
            if (c == 1) busy_c1 = busy_v[k];
            if (mr[k] && first_rd < 0) first_rd = c;
            if (prev_mr && prev_wr && mr[k] && addr[k] != prev_addr) proto_err++;
            if (prev_mr && !prev_wr && mr[k] && (k != 0 || addr[k] == prev_addr)) proto_err++;
            if (mr[k] && addr[k] == 1'b0 && sid_l > 0) begin
                wr[k] = 1'b1; sid_l--; n_stall++;
            end else if (mr[k] && addr[k] == 1'b1 && sts_l > 0) begin
                wr[k] = 1'b1; sts_l--; n_stall++;
            end else begin
                wr[k] = 1'b0;
            end
            if (mr[k] && !wr[k]) n_acc++;
            prev_mr   = mr[k];
            prev_wr   = wr[k];
            prev_addr = addr[k];
            if (done_v[k]) begin
                done_cyc = c;
                break;
            end
        end
        wr[k]      = 1'b0;
        start_v[k] = 1'b0;
        @(negedge clk);
        check({tag, " done_cycle"}, done_cyc, exp_done);
        check({tag, " first_read_cycle"}, first_rd, 1);
        check({tag, " busy_cycle1"}, busy_c1, 1'b1);
        check({tag, " accepted_reads"}, n_acc, exp_acc);
        check({tag, " stall_cycles"}, n_stall, exp_stall);
        check({tag, " protocol_errors"}, proto_err, 0);
        check({tag, " idle_after_done"}, {busy_v[k], done_v[k]}, 2'b00);
    endtask

    initial begin
        int bad;
        reset_n = 1'b0;
        id_data = GOOD_ID;
        ts_data = GOOD_TS;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            wr[k]      = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_flags_%0d", k),
                  {busy_v[k], done_v[k], mr[k], addr[k], idok[k], tsok[k], tmo[k]}, 7'd0);
            check($sformatf("reset_values_%0d", k), idv[k] | tsv[k], 32'd0);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Latency 1, no stall, both words good
        run_seq(1, 0, 0, 1'b0, 5, 2, 0, "l1_nostall");
        check("l1_nostall ok", {idok[1], tsok[1], tmo[1]}, 3'b110);
        check("l1_nostall id_value", idv[1], GOOD_ID);
        check("l1_nostall ts_value", tsv[1], GOOD_TS);

        // Latency 1, ID read stalled three cycles
        run_seq(1, 3, 0, 1'b0, 8, 2, 3, "l1_stall3");
        check("l1_stall3 ok", {idok[1], tsok[1], tmo[1]}, 3'b110);

        // Timestamp mismatch, then results must hold while idle
        ts_data = BAD_TS;
        run_seq(1, 0, 0, 1'b0, 5, 2, 0, "l1_badts");
        check("l1_badts ok", {idok[1], tsok[1], tmo[1]}, 3'b100);
        check("l1_badts ts_value", tsv[1], BAD_TS);
        repeat (3) @(negedge clk);
        check("l1_badts hold ts_value", tsv[1], BAD_TS);
        check("l1_badts hold ok", {idok[1], tsok[1]}, 2'b10);
        ts_data = GOOD_TS;

        // Waitrequest stuck on timestamp read with timeout 4
        run_seq(1, 0, 1000, 1'b0, 7, 1, 4, "l1_timeout");
        check("l1_timeout ok", {idok[1], tsok[1], tmo[1]}, 3'b101);
        check("l1_timeout id_value", idv[1], GOOD_ID);
        check("l1_timeout ts_value", tsv[1], 32'd0);

        // Latency 0 and 3 sweeps
        run_seq(0, 0, 0, 1'b0, 3, 2, 0, "l0");
        check("l0 ok", {idok[0], tsok[0], tmo[0]}, 3'b110);
        check("l0 values", {idv[0] ^ GOOD_ID} | {tsv[0] ^ GOOD_TS}, 32'd0);
        run_seq(2, 0, 0, 1'b0, 9, 2, 0, "l3");
        check("l3 ok", {idok[2], tsok[2], tmo[2]}, 3'b110);
        check("l3 values", {idv[2] ^ GOOD_ID} | {tsv[2] ^ GOOD_TS}, 32'd0);

        // Start pulses while busy are ignored; timeout cleared by new start
        run_seq(1, 0, 0, 1'b1, 5, 2, 0, "l1_busy_start");
        check("l1_busy_start ok", {idok[1], tsok[1], tmo[1]}, 3'b110);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mr[1] || busy_v[1]) bad++;
        end
        check("l1_busy_start no_requeue", bad, 0);

        // Reset during LAT_ID: outputs clear at once, in-flight data discarded
        @(negedge clk);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        check("midreset read_cycle1", {mr[1], addr[1]}, 2'b10);
        @(negedge clk);
        check("midreset in_lat", {busy_v[1], mr[1]}, 2'b10);
        #2 reset_n = 1'b0;
        #1;
        check("midreset flags", {busy_v[1], done_v[1], mr[1], addr[1], idok[1], tsok[1], tmo[1]}, 7'd0);
        check("midreset values", idv[1] | tsv[1], 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mr[1] || busy_v[1] || idv[1] != 32'd0) bad++;
        end
        check("midreset quiet_after", bad, 0);

        // Normal operation resumes after reset
        run_seq(1, 0, 0, 1'b0, 5, 2, 0, "l1_recover");
        check("l1_recover ok", {idok[1], tsok[1], tmo[1]}, 3'b110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit reached, required bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
